uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port recv_data, output, 8 bits: last correctly framed byte.
REQ-006 The block SHALL have port recv_ok, output, 1 bit: single-cycle strobe, recv_data valid and new.
REQ-007 The block SHALL have port frame_error, output, 1 bit: single-cycle strobe, stop bit sampled low.
REQ-008 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-009 rxd SHALL pass through a two-flop synchronizer, both flops reset to 1; all decisions use the second flop (rxd_s).
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-011 The bit-timing counter SHALL be clog2(CLKS_PER_BIT) bits wide; it SHALL clear on every state transition and on each sampled data bit.
REQ-012 In IDLE, rxd_s==0 SHALL cause a transition to START on the next edge.
REQ-013 In START, rxd_s SHALL be sampled when the counter reaches CLKS_PER_BIT/2-1 (integer division): 0 -> DATA with bit index 0; 1 -> IDLE, no strobe (glitch rejection).
REQ-014 In DATA, rxd_s SHALL be sampled when the counter reaches CLKS_PER_BIT-1, into shift register bit [index], LSB first.
REQ-015 After the sample with index 7 the FSM SHALL enter STOP; the 3-bit index SHALL never wrap within a frame.
REQ-016 In STOP, rxd_s SHALL be sampled when the counter reaches CLKS_PER_BIT-1.
REQ-017 A STOP sample of 1 SHALL load recv_data from the shift register, pulse recv_ok for exactly one cycle (the cycle after the sample), and enter IDLE.
REQ-018 A STOP sample of 0 SHALL pulse frame_error for one cycle, leave recv_data unchanged, not assert recv_ok, and enter BREAK.
REQ-019 In BREAK the FSM SHALL remain until rxd_s==1, then enter IDLE; a held-low line SHALL produce exactly one frame_error.
REQ-020 recv_ok and frame_error SHALL never be high in the same cycle.
REQ-021 recv_data SHALL hold its value between recv_ok strobes.
REQ-022 Back-to-back frames SHALL be received with zero idle bits between stop bit and next start bit: IDLE may see rxd_s==0 in its first cycle.
REQ-023 Latency SHALL be fixed: recv_ok rises 2 + 1 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 1 cycles after the rxd falling edge (±1 for synchronizer phase).
REQ-024 No internal buffering SHALL exist; each recv_ok strobe is consumed by the downstream buffer controller in that cycle.

Reset
REQ-025 With reset high at a clock edge, the FSM SHALL enter IDLE; counter, bit index and shift register SHALL clear to 0; synchronizer flops SHALL be set to 1.
REQ-026 Outputs during and after reset SHALL be: recv_data=0x00, recv_ok=0, frame_error=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no strobe; reception SHALL restart only at a new falling edge after reset deasserts, not at a falling edge seen during reset.

Verification (CLKS_PER_BIT=16)
REQ-028 Single byte 0xA5, 8N1, ideal timing -> exactly one recv_ok, recv_data=0xA5, frame_error never high.
REQ-029 Bytes 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three recv_ok strobes in order, data matching, spacing exactly 160 cycles.
REQ-030 rxd low for 5 cycles, then high -> no recv_ok, no frame_error, busy drops back to 0 within 10 cycles.
REQ-031 Byte 0x3C with stop bit driven 0, then line held low for 100 cycles, then high -> exactly one frame_error, no recv_ok, recv_data unchanged; the following frame 0x81 is received correctly.
REQ-032 Reset pulsed during data bit 4 of a 0xF0 frame -> no strobe, outputs at reset values; the following frame 0x12 yields recv_data=0x12.
REQ-033 Frame 0x6B with bit period skewed ±5% (15 and 17 cycles) -> recv_ok with recv_data=0x6B in both cases.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with start-bit glitch rejection and break handling
// Mid-bit sampling driven by a per-state bit-timing counter; strobes and busy are registered.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] recv_data,
    output logic       recv_ok,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_rxd_s;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_index;
    logic [7:0]      r_shift;
    logic [7:0]      r_recv_data;
    logic            r_recv_ok;
    logic            r_frame_error;
    logic            r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_rxd_s       <= 1'b1;
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_index       <= '0;
            r_shift       <= '0;
            r_recv_data   <= '0;
            r_recv_ok     <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sync1       <= rxd;
            r_rxd_s       <= r_sync1;
            r_recv_ok     <= 1'b0;
            r_frame_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (!r_rxd_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                // A start bit that is high again at its midpoint was a glitch.
                S_START: begin
                    if (r_count == HALF_LAST) begin
                        r_count <= '0;
                        if (!r_rxd_s) begin
                            r_state <= S_DATA;
                            r_index <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_count == BIT_LAST) begin
                        r_count          <= '0;
                        r_shift[r_index] <= r_rxd_s;
                        if (r_index == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_count == BIT_LAST) begin
                        r_count <= '0;
                        if (r_rxd_s) begin
                            r_recv_data <= r_shift;
                            r_recv_ok   <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= S_BREAK;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                // Wait out a held-low line so it reports only one frame error.
                S_BREAK: begin
                    r_count <= '0;
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign recv_data   = r_recv_data;
    assign recv_ok     = r_recv_ok;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver at 16 clocks per bit
// Clock period is 10 time units; a negedge monitor logs strobes for the scenario tasks.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] recv_data;
    logic       recv_ok;
    logic       frame_error;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int ok_count     = 0;
    int fe_count     = 0;
    int both_count   = 0;
    int last_fall    = 0;
    logic [7:0] ok_data [$];
    int         ok_time [$];

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .recv_data   (recv_data),
        .recv_ok     (recv_ok),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (recv_ok) begin
            ok_count <= ok_count + 1;
            ok_data.push_back(recv_data);
            ok_time.push_back(cycle);
        end
        if (frame_error) fe_count <= fe_count + 1;
        if (recv_ok && frame_error) both_count <= both_count + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        last_fall = cycle;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        rxd = stop;
        tick(CPB);
    endtask

    // Bit edges land 9 units after a clock edge, then drift by the odd bit time.
    task automatic send_frame_timed(input logic [7:0] d, input int bit_t);
        @(posedge clk);
        #9;
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bit_t);
        end
        rxd = 1'b1;
        #(bit_t);
        tick(1);
    endtask

    task automatic test_reset();
        tick(4);
        tests_run++;
        if (recv_data !== 8'h00) begin tests_failed++; $display("FAIL reset_recv_data: got %h expected 00", recv_data); end
        tests_run++;
        if (recv_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_recv_ok: got %b expected 0", recv_ok); end
        tests_run++;
        if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        tick(4);
        tests_run++;
        if (busy !== 1'b0 || recv_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset_idle: busy %b data %h expected 0 / 00", busy, recv_data);
        end
    endtask

    task automatic test_single_byte();
        int ob = ok_count;
        int fb = fe_count;
        int qb = ok_data.size();
        logic [7:0] got = 8'h00;
        int lat = -1;
        send_frame(8'hA5, 1'b1);
        tick(10);
        if (ok_data.size() > qb) begin
            got = ok_data[qb];
            lat = ok_time[qb] - last_fall;
        end
        tests_run++;
        if (ok_count - ob !== 1) begin tests_failed++; $display("FAIL single_ok_count: got %0d expected 1", ok_count - ob); end
        tests_run++;
        if (got !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h expected a5", got); end
        tests_run++;
        if (lat < 155 || lat > 157) begin tests_failed++; $display("FAIL single_latency: got %0d expected 155..157", lat); end
        tests_run++;
        if (fe_count - fb !== 0) begin tests_failed++; $display("FAIL single_frame_error: got %0d expected 0", fe_count - fb); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3] = '{8'h00, 8'hFF, 8'h55};
        int ob = ok_count;
        int fb = fe_count;
        int qb = ok_data.size();
        send_frame(exp_d[0], 1'b1);
        send_frame(exp_d[1], 1'b1);
        send_frame(exp_d[2], 1'b1);
        tick(10);
        tests_run++;
        if (ok_count - ob !== 3) begin tests_failed++; $display("FAIL b2b_ok_count: got %0d expected 3", ok_count - ob); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] got = 8'hxx;
            if (ok_data.size() > qb + i) got = ok_data[qb + i];
            tests_run++;
            if (got !== exp_d[i]) begin tests_failed++; $display("FAIL b2b_data%0d: got %h expected %h", i, got, exp_d[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            int gap = -1;
            if (ok_time.size() > qb + i) gap = ok_time[qb + i] - ok_time[qb + i - 1];
            tests_run++;
            if (gap !== 160) begin tests_failed++; $display("FAIL b2b_spacing%0d: got %0d expected 160", i, gap); end
        end
        tests_run++;
        if (fe_count - fb !== 0) begin tests_failed++; $display("FAIL b2b_frame_error: got %0d expected 0", fe_count - fb); end
    endtask

    task automatic test_glitch();
        int ob = ok_count;
        int fb = fe_count;
        int waited = 0;
        rxd = 1'b0;
        tick(5);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
        rxd = 1'b1;
        while (busy && waited < 10) begin
            tick(1);
            waited++;
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_drop: got %b expected 0 within 10 cycles", busy); end
        tick(20);
        tests_run++;
        if (ok_count - ob !== 0 || fe_count - fb !== 0) begin
            tests_failed++;
            $display("FAIL glitch_strobes: ok %0d fe %0d expected 0 / 0", ok_count - ob, fe_count - fb);
        end
    endtask

    task automatic test_frame_error();
        int ob = ok_count;
        int fb = fe_count;
        send_frame(8'h3C, 1'b0);
        tick(50);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL break_busy: got %b expected 1", busy); end
        tick(50);
        rxd = 1'b1;
        tick(10);
        tests_run++;
        if (fe_count - fb !== 1) begin tests_failed++; $display("FAIL break_fe_count: got %0d expected 1", fe_count - fb); end
        tests_run++;
        if (ok_count - ob !== 0) begin tests_failed++; $display("FAIL break_ok_count: got %0d expected 0", ok_count - ob); end
        tests_run++;
        if (recv_data !== 8'h55) begin tests_failed++; $display("FAIL break_data_held: got %h expected 55", recv_data); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL break_exit_busy: got %b expected 0", busy); end
        send_frame(8'h81, 1'b1);
        tick(10);
        tests_run++;
        if (ok_count - ob !== 1) begin tests_failed++; $display("FAIL after_break_ok_count: got %0d expected 1", ok_count - ob); end
        tests_run++;
        if (recv_data !== 8'h81) begin tests_failed++; $display("FAIL after_break_data: got %h expected 81", recv_data); end
        tests_run++;
        if (fe_count - fb !== 1) begin tests_failed++; $display("FAIL after_break_fe_count: got %0d expected 1", fe_count - fb); end
    endtask

    task automatic test_reset_mid_frame();
        int ob = ok_count;
        int fb = fe_count;
        rxd = 1'b0;
        tick(CPB);
        tick(4 * CPB);
        rxd = 1'b1;
        tick(8);
        reset = 1'b1;
        tick(2);
        tests_run++;
        if (recv_data !== 8'h00 || recv_ok !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: data %h ok %b fe %b busy %b expected 00 0 0 0",
                     recv_data, recv_ok, frame_error, busy);
        end
        reset = 1'b0;
        tick(6 + 3 * CPB + CPB + 10);
        tests_run++;
        if (ok_count - ob !== 0 || fe_count - fb !== 0) begin
            tests_failed++;
            $display("FAIL midreset_strobes: ok %0d fe %0d expected 0 / 0", ok_count - ob, fe_count - fb);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        send_frame(8'h12, 1'b1);
        tick(10);
        tests_run++;
        if (ok_count - ob !== 1) begin tests_failed++; $display("FAIL midreset_next_count: got %0d expected 1", ok_count - ob); end
        tests_run++;
        if (recv_data !== 8'h12) begin tests_failed++; $display("FAIL midreset_next_data: got %h expected 12", recv_data); end
    endtask

    // 152 and 168 time units are 16-cycle bits shortened / lengthened by 5%.
    task automatic test_skew();
        int bit_times [2] = '{152, 168};
        for (int k = 0; k < 2; k++) begin
            int ob = ok_count;
            int fb = fe_count;
            send_frame_timed(8'h6B, bit_times[k]);
            tick(10);
            tests_run++;
            if (ok_count - ob !== 1) begin tests_failed++; $display("FAIL skew%0d_ok_count: got %0d expected 1", bit_times[k], ok_count - ob); end
            tests_run++;
            if (recv_data !== 8'h6B) begin tests_failed++; $display("FAIL skew%0d_data: got %h expected 6b", bit_times[k], recv_data); end
            tests_run++;
            if (fe_count - fb !== 0) begin tests_failed++; $display("FAIL skew%0d_frame_error: got %0d expected 0", bit_times[k], fe_count - fb); end
        end
    endtask

    task automatic test_exclusive();
        tests_run++;
        if (both_count !== 0) begin tests_failed++; $display("FAIL ok_fe_same_cycle: got %0d expected 0", both_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_skew();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
